// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - knight's-tour replay sequencer and UART command mux
// Splits each one-hot solver move into a vertical then a horizontal robot command.
module tour_cmd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

  localparam logic [4:0] LAST_IDX = 5'd23;

  state_t      state, nxt;
  logic [4:0]  idx_nxt;
  logic [15:0] v_cmd, h_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= nxt;
      mv_indx <= idx_nxt;
    end
  end

  // Move table: {opcode, heading, squares} for each leg; anything not one-hot
  // falls back to a harmless zero-length north move.
  always_comb begin
    v_cmd = 16'h2000;
    h_cmd = 16'h2000;
    case (move)
      8'h01: begin v_cmd = 16'h2002; h_cmd = 16'h33F1; end
      8'h02: begin v_cmd = 16'h2002; h_cmd = 16'h3BF1; end
      8'h04: begin v_cmd = 16'h2001; h_cmd = 16'h33F2; end
      8'h08: begin v_cmd = 16'h27F1; h_cmd = 16'h33F2; end
      8'h10: begin v_cmd = 16'h27F2; h_cmd = 16'h33F1; end
      8'h20: begin v_cmd = 16'h27F2; h_cmd = 16'h3BF1; end
      8'h40: begin v_cmd = 16'h27F1; h_cmd = 16'h3BF2; end
      8'h80: begin v_cmd = 16'h2001; h_cmd = 16'h3BF2; end
      default: begin v_cmd = 16'h2000; h_cmd = 16'h2000; end
    endcase
  end

  always_comb begin
    nxt              = state;
    idx_nxt          = mv_indx;
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = 8'h5A;
    if (state != IDLE) begin
      clr_cmd_rdy_UART = 1'b0;
      cmd_rdy          = 1'b0;
      cmd              = (state == VERT || state == WAIT_V) ? v_cmd : h_cmd;
    end
    case (state)
      IDLE: begin
        resp = 8'hA5;
        if (start_tour) begin
          idx_nxt = 5'd0;
          nxt     = VERT;
        end
      end
      VERT: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt = WAIT_V;
      end
      WAIT_V: begin
        if (send_resp) nxt = HORZ;
      end
      HORZ: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt = WAIT_H;
      end
      WAIT_H: begin
        if (mv_indx == LAST_IDX) resp = 8'hA5;
        if (send_resp) begin
          if (mv_indx == LAST_IDX) begin
            nxt = IDLE;
          end else begin
            idx_nxt = mv_indx + 5'd1;
            nxt     = VERT;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - self-checking bench for tour_cmd
// Tour progress is modelled as a command count 0..47 plus an outstanding flag.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0] tour_mem [32];
  int dx_tab [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  int dy_tab [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int hs_cnt = 0;

  bit m_active = 1'b0;
  bit m_issued = 1'b0;
  int m_n = 0;

  tour_cmd dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
  );

  assign move = tour_mem[mv_indx];

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit vert);
    int b;
    int d;
    logic [15:0] r;
    if ($countones(m) != 1) return 16'h2000;
    b = 0;
    for (int i = 0; i < 8; i++) if (m[i]) b = i;
    d = vert ? dy_tab[b] : dx_tab[b];
    r[3:0] = 4'(d < 0 ? -d : d);
    if (vert) r[15:4] = {4'h2, (d > 0) ? 8'h00 : 8'h7F};
    else      r[15:4] = {4'h3, (d > 0) ? 8'hBF : 8'h3F};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 48 commands per tour; even count = vertical leg, odd = horizontal.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_issued <= 1'b0;
      m_n      <= 0;
    end else if (!m_active) begin
      if (start_tour) begin
        m_active <= 1'b1;
        m_issued <= 1'b0;
        m_n      <= 0;
      end
    end else if (!m_issued) begin
      if (clr_cmd_rdy) m_issued <= 1'b1;
    end else if (send_resp) begin
      m_issued <= 1'b0;
      if (m_n == 47) m_active <= 1'b0;
      else           m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mv_indx", {27'd0, mv_indx}, 32'(m_n / 2));
      if (!m_active) begin
        chk("idle_cmd", {16'd0, cmd}, {16'd0, cmd_UART});
        chk("idle_cmd_rdy", {31'd0, cmd_rdy}, {31'd0, cmd_rdy_UART});
        chk("idle_clr_uart", {31'd0, clr_cmd_rdy_UART}, {31'd0, clr_cmd_rdy});
        chk("idle_resp", {24'd0, resp}, 32'hA5);
      end else begin
        chk("tour_cmd_rdy", {31'd0, cmd_rdy}, {31'd0, !m_issued});
        chk("tour_clr_uart", {31'd0, clr_cmd_rdy_UART}, 32'd0);
        chk("tour_resp", {24'd0, resp}, (m_issued && m_n == 47) ? 32'hA5 : 32'h5A);
        if (!m_issued)
          chk("tour_cmd", {16'd0, cmd}, {16'd0, exp_cmd(tour_mem[m_n / 2], (m_n % 2) == 0)});
        if (cmd_rdy && clr_cmd_rdy) hs_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic take();
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic finish_cmd();
    send_resp = 1'b1;
    cyc();
    send_resp = 1'b0;
  endtask

  initial begin
    int budget;
    start_tour = 1'b0;
    cmd_UART = 16'h0;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h00;
    repeat (3) cyc();
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk("rst_mv_indx", {27'd0, mv_indx}, 32'd0);
    chk("rst_resp", {24'd0, resp}, 32'hA5);

    cmd_UART = 16'h2BF1; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    chk("pass_cmd", {16'd0, cmd}, 32'h2BF1);
    chk("pass_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("pass_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
    cyc();
    clr_cmd_rdy = 1'b0;

    tour_mem[0] = 8'h80; tour_mem[1] = 8'h01; tour_mem[2] = 8'h10;
    for (int i = 3; i < 24; i++) tour_mem[i] = 8'(1 << (i % 8));
    cmd_UART = 16'h1111; start_tour = 1'b1;
    #1;
    chk("start_pass_cmd", {16'd0, cmd}, 32'h1111);
    cyc();
    start_tour = 1'b0;
    chk("m0_vert", {16'd0, cmd}, 32'h2001);
    chk("m0_rdy", {31'd0, cmd_rdy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_cmd", {16'd0, cmd}, 32'h2001);
      chk("stall_rdy", {31'd0, cmd_rdy}, 32'd1);
    end
    finish_cmd();
    chk("stray_resp_rdy", {31'd0, cmd_rdy}, 32'd1);
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    chk("restart_ignored", {16'd0, cmd}, 32'h2001);
    take();
    chk("taken_rdy", {31'd0, cmd_rdy}, 32'd0);
    cyc();
    finish_cmd();
    chk("m0_horz", {16'd0, cmd}, 32'h3BF2);
    take();
    chk("m0_wait_resp", {24'd0, resp}, 32'h5A);
    finish_cmd();
    chk("m1_idx", {27'd0, mv_indx}, 32'd1);
    chk("m1_vert", {16'd0, cmd}, 32'h2002);
    take(); finish_cmd();
    chk("m1_horz", {16'd0, cmd}, 32'h33F1);
    take(); finish_cmd();
    chk("m2_vert", {16'd0, cmd}, 32'h27F2);
    take(); finish_cmd();
    chk("m2_horz", {16'd0, cmd}, 32'h33F1);
    take(); finish_cmd();
    for (int i = 3; i < 7; i++) begin
      take(); finish_cmd(); take(); finish_cmd();
    end
    take(); finish_cmd(); take();
    chk("pre_rst_idx", {27'd0, mv_indx}, 32'd7);
    cmd_UART = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_idx", {27'd0, mv_indx}, 32'd0);
    chk("async_rst_cmd", {16'd0, cmd}, 32'h1234);
    chk("async_rst_resp", {24'd0, resp}, 32'hA5);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 24; i++)
        tour_mem[i] = ($urandom_range(11) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(7));
      hs_cnt = 0;
      cmd_rdy_UART = 1'b1;
      start_tour = 1'b1;
      cyc();
      start_tour = 1'b0;
      budget = 0;
      while (m_active && budget < 4000) begin
        clr_cmd_rdy  = ($urandom_range(2) == 0);
        send_resp    = ($urandom_range(2) == 0);
        start_tour   = ($urandom_range(9) == 0);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = $urandom_range(1) != 0;
        cyc();
        budget++;
      end
      clr_cmd_rdy = 1'b0; send_resp = 1'b0; start_tour = 1'b0;
      chk("tour_timeout", {31'd0, m_active}, 32'd0);
      chk("tour_handshakes", 32'(hs_cnt), 32'd48);
      chk("tour_end_idx", {27'd0, mv_indx}, 32'd23);
      chk("tour_end_resp", {24'd0, resp}, 32'hA5);
      repeat (3) cyc();
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Reader and sequencer for the knight's-tour solution. After the solver pulses done, tour_cmd walks the 24-entry move list through the solver's indx/move read port. It converts each one-hot move into two robot commands, vertical then horizontal, and issues them to the command processor one at a time with a ready/clear handshake. When no tour is running, it is a transparent mux between the UART command path and the command processor.

## Interface
Parameters: none.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start_tour  in  1  one-cycle pulse; starts replay of a solved tour (accepted in IDLE only)
- move  in  8  one-hot move returned by the solver for mv_indx (combinational read)
- mv_indx  out  5  index of the move being read out, 0..23
- cmd_UART  in  16  command from the UART wrapper
- cmd_rdy_UART  in  1  cmd_UART valid
- clr_cmd_rdy_UART  out  1  acknowledge to the UART wrapper
- cmd  out  16  command to the command processor
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor has taken cmd
- send_resp  in  1  command processor finished the current command
- resp  out  8  response byte to the UART

## Operation
- Move encoding (bit: dx,dy): 0:(-1,+2), 1:(+1,+2), 2:(-2,+1), 3:(-2,-1), 4:(-1,-2), 5:(+1,-2), 6:(+2,-1), 7:(+2,+1).
- Command format:
  - cmd[15:12] opcode: 4'h2 = move, 4'h3 = move with fanfare.
  - cmd[11:4] heading: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
  - cmd[3:0] square count (|dy| or |dx|).
- Vertical command: heading north if dy>0, south if dy<0; opcode 4'h2.
- Horizontal command: heading east if dx>0, west if dx<0; opcode 4'h3.
- A move value that is not one-hot produces 16'h2000 for both commands. No error is flagged.
- FSM states: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: mux selects the UART path, so cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy. On start_tour, clear mv_indx to 0 and go to VERT.
  - VERT: cmd = vertical command, cmd_rdy=1. On clr_cmd_rdy, go to WAIT_V.
  - WAIT_V: cmd_rdy=0. On send_resp, go to HORZ.
  - HORZ: cmd = horizontal command, cmd_rdy=1. On clr_cmd_rdy, go to WAIT_H.
  - WAIT_H: cmd_rdy=0. On send_resp:
    - if mv_indx==23, go to IDLE;
    - else increment mv_indx and go to VERT.
- clr_cmd_rdy_UART is held at 0 in every non-IDLE state. UART commands are held off, not dropped.
- resp rules:
  - 8'h5A while in any tour state, except in WAIT_H when mv_indx==23;
  - 8'hA5 in WAIT_H when mv_indx==23, and in IDLE.
- start_tour outside IDLE is ignored.
- A send_resp arriving in VERT or HORZ (no command outstanding) is ignored.

## Timing
- Reset values: state IDLE, mv_indx 0. Outputs are therefore the passthrough values and resp=8'hA5.
- Only state and mv_indx are registered. cmd, cmd_rdy, clr_cmd_rdy_UART and resp are combinational from state, mv_indx, move and the UART inputs.
- Latency: cmd_rdy asserts the cycle after the start_tour pulse. cmd_rdy deasserts the cycle after clr_cmd_rdy is sampled.
- The solver read is combinational. A new mv_indx is visible on move, and therefore on cmd, in the same cycle VERT is entered.
- start_tour and cmd_rdy_UART asserted together in IDLE:
  - start_tour wins;
  - the passthrough shows the UART command for that one cycle only;
  - clr_cmd_rdy_UART follows clr_cmd_rdy in that cycle.
- Reset mid-tour: the FSM returns to IDLE immediately (asynchronous). No partial command is re-issued.
- One tour is exactly 48 commands (24 moves × 2) and 48 clr_cmd_rdy/send_resp pairs.

## Test plan
- Idle passthrough: cmd_UART=16'h2BF1, cmd_rdy_UART=1 -> cmd=16'h2BF1 and cmd_rdy=1 same cycle. clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1. resp=8'hA5.
- Single move bit7, start_tour at idx 0:
  - first command 16'h2001 (north 1);
  - after clr/send_resp, 16'h3BF2 (east 2, fanfare);
  - mv_indx then advances to 1.
- Move bit0 -> 16'h2002 then 16'h33F1. Move bit4 -> 16'h27F2 then 16'h33F1.
- Full 24-move replay with a scoreboard of 48 commands:
  - mv_indx steps 0..23;
  - resp=8'h5A until WAIT_H at idx 23, then 8'hA5;
  - returns to IDLE;
  - clr_cmd_rdy_UART stays 0 during the tour despite cmd_rdy_UART=1.
- Handshake abuse and reset:
  - stall clr_cmd_rdy 10 cycles -> cmd stays stable and cmd_rdy held;
  - stray send_resp in VERT -> no state change;
  - start_tour mid-tour -> ignored;
  - rst_n low in WAIT_H at idx 7 -> IDLE and mv_indx=0 immediately.
